// File: rtl/fault_pkg.sv
// rtl/fault_pkg.sv - shared types and sizing helpers for the stuck-at fault campaign controller
package fault_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, COMPARE, NEXT_FAULT, DONE} state_e;
  typedef enum logic {SA0 = 1'b0, SA1 = 1'b1} pol_e;

  function automatic int det_count_w(input int n_sites);
    return $clog2(2 * n_sites + 1);
  endfunction

  function automatic int site_idx_w(input int n_sites);
    return (n_sites > 1) ? $clog2(n_sites) : 1;
  endfunction

endpackage

// File: rtl/fault_mask_inject.sv
// rtl/fault_mask_inject.sv - registered one-hot stuck-at masks and combinational injection onto fault sites
module fault_mask_inject
  import fault_pkg::*;
#(
  parameter int N_SITES = 10,
  parameter int SW      = site_idx_w(N_SITES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [SW-1:0]      site,
  input  pol_e               pol,
  input  logic [N_SITES-1:0] site_in,
  output logic [N_SITES-1:0] site_out
);

  logic [N_SITES-1:0] sa0_q, sa0_d;
  logic [N_SITES-1:0] sa1_q, sa1_d;

  always_comb begin
    sa0_d = '0;
    sa1_d = '0;
    for (int i = 0; i < N_SITES; i++) begin
      if (en && site == SW'(i)) begin
        if (pol == SA1) sa1_d[i] = 1'b1;
        else            sa0_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa0_q <= '0;
      sa1_q <= '0;
    end else begin
      sa0_q <= sa0_d;
      sa1_q <= sa1_d;
    end
  end

  assign site_out = (site_in & ~sa0_q) | sa1_q;

endmodule

// File: rtl/fault_campaign_ctrl.sv
// rtl/fault_campaign_ctrl.sv - self-sequencing stuck-at fault campaign with exhaustive vectors and fault dropping
module fault_campaign_ctrl
  import fault_pkg::*;
#(
  parameter int N_SITES = 10,
  parameter int IN_W    = 4,
  parameter int OUT_W   = 2,
  parameter int SETTLE  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [N_SITES-1:0]                site_in,
  output logic [N_SITES-1:0]                site_out,
  output logic [IN_W-1:0]                   tv,
  input  logic [OUT_W-1:0]                  golden_y,
  input  logic [OUT_W-1:0]                  faulty_y,
  output logic                              busy,
  output logic                              done,
  output logic [2*N_SITES-1:0]              detected,
  output logic [det_count_w(N_SITES)-1:0]   det_count
);

  localparam int SW = site_idx_w(N_SITES);
  localparam int CW = det_count_w(N_SITES);
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e               state_q, state_d;
  logic [IN_W-1:0]      vec_q, vec_d;
  logic [SW-1:0]        site_q, site_d;
  pol_e                 pol_q, pol_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [2*N_SITES-1:0] det_q, det_d;
  logic [CW-1:0]        dc_q, dc_d;
  logic                 mask_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      site_q  <= '0;
      pol_q   <= SA0;
      cnt_q   <= '0;
      det_q   <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      site_q  <= site_d;
      pol_q   <= pol_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    site_d  = site_q;
    pol_d   = pol_q;
    cnt_d   = cnt_q;
    det_d   = det_q;
    dc_d    = dc_q;
    // abort outranks everything, including a start in IDLE; results are left intact
    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      site_d  = '0;
      pol_d   = SA0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            det_d   = '0;
            dc_d    = '0;
            site_d  = '0;
            pol_d   = SA0;
            vec_d   = '0;
            cnt_d   = '0;
            state_d = APPLY;
          end
        end
        APPLY: begin
          if (cnt_q == TW'(SETTLE - 1)) begin
            cnt_d   = '0;
            state_d = COMPARE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        COMPARE: begin
          if (golden_y != faulty_y) begin
            for (int i = 0; i < N_SITES; i++) begin
              if (site_q == SW'(i)) begin
                if (pol_q == SA1) det_d[2*i+1] = 1'b1;
                else              det_d[2*i]   = 1'b1;
              end
            end
            dc_d    = dc_q + CW'(1);
            state_d = NEXT_FAULT;
          end else if (vec_q == '1) begin
            state_d = NEXT_FAULT;
          end else begin
            vec_d   = vec_q + IN_W'(1);
            state_d = APPLY;
          end
        end
        NEXT_FAULT: begin
          vec_d = '0;
          if (pol_q == SA0) begin
            pol_d   = SA1;
            state_d = APPLY;
          end else if (site_q == SW'(N_SITES - 1)) begin
            pol_d   = SA0;
            site_d  = '0;
            state_d = DONE;
          end else begin
            pol_d   = SA0;
            site_d  = site_q + SW'(1);
            state_d = APPLY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // masks are loaded from next-state so they are already valid in the first APPLY cycle
  assign mask_en = (state_d == APPLY) || (state_d == COMPARE);

  fault_mask_inject #(
    .N_SITES (N_SITES)
  ) u_inject (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mask_en),
    .site     (site_d),
    .pol      (pol_d),
    .site_in  (site_in),
    .site_out (site_out)
  );

  assign tv        = vec_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign detected  = det_q;
  assign det_count = dc_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb/tb_fault_campaign_ctrl.sv - self-checking bench for fault_campaign_ctrl
module tb_fault_campaign_ctrl;

  localparam int N  = 10;
  localparam int IW = 4;
  localparam int OW = 2;
  localparam int S  = 1;
  localparam int NV = 1 << IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [N-1:0]   site_in, site_out;
  logic [IW-1:0]  tv;
  logic [OW-1:0]  golden_y, faulty_y;
  logic           busy, done;
  logic [2*N-1:0] detected;
  logic [4:0]     det_count;

  int             mode = 0;
  logic [N-1:0]   site_in_r = '0;
  logic [N-1:0]   m0 = '0;
  logic [N-1:0]   m1 = '0;
  logic [NV*N-1:0] nets_flat = '0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int             md;
    logic [N-1:0]   sin;
    logic [2*N-1:0] det;
    int             cyc;
  } vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;

  fault_campaign_ctrl #(.N_SITES(N), .IN_W(IW), .OUT_W(OW), .SETTLE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .site_in   (site_in),
    .site_out  (site_out),
    .tv        (tv),
    .golden_y  (golden_y),
    .faulty_y  (faulty_y),
    .busy      (busy),
    .done      (done),
    .detected  (detected),
    .det_count (det_count)
  );

  // Environment CUT: returns {golden, faulty} for the given fault-free and injected nets
  function automatic logic [3:0] cut_y(input int md, input logic [IW-1:0] v,
                                       input logic [N-1:0] g_nets, input logic [N-1:0] f_nets,
                                       input logic [N-1:0] a, input logic [N-1:0] b);
    logic [1:0] g, f;
    g = 2'b10;
    f = 2'b10;
    case (md)
      1: f[0] = f[0] ^ (f_nets[2] & ~g_nets[2] & (v == 4'h0));
      2: f[0] = f[0] ^ (~f_nets[0] & g_nets[0] & (v == 4'hF));
      3: f[0] = f[0] ^ (|(f_nets ^ g_nets));
      4: begin
        g = {&(g_nets | ~b), ^(g_nets & a)};
        f = {&(f_nets | ~b), ^(f_nets & a)};
      end
      default: ;
    endcase
    return {g, f};
  endfunction

  always_comb begin
    site_in = (mode == 4) ? nets_flat[int'(tv)*N +: N] : site_in_r;
    {golden_y, faulty_y} = cut_y(mode, tv, site_in, site_out, m0, m1);
  end

  // Campaign outcome from the rules: each tested vector costs S+1 cycles, each fault one more,
  // a fault stops at its first detecting vector; cycle 1 is the first cycle after the start edge.
  function automatic void predict(input int md, input int abort_cyc,
                                  output logic [2*N-1:0] det, output int done_cyc);
    int cyc;
    logic [N-1:0] g, f;
    logic [3:0] y;
    cyc = 0;
    det = '0;
    done_cyc = 0;
    for (int s = 0; s < N; s++) begin
      for (int p = 0; p < 2; p++) begin
        for (int v = 0; v < NV; v++) begin
          cyc = cyc + S + 1;
          if (abort_cyc > 0 && cyc >= abort_cyc) return;
          g = (md == 4) ? nets_flat[v*N +: N] : site_in_r;
          f = g;
          f[s] = (p == 1);
          y = cut_y(md, IW'(v), g, f, m0, m1);
          if (y[3:2] != y[1:0]) begin
            det[2*s+p] = 1'b1;
            break;
          end
        end
        cyc = cyc + 1;
      end
    end
    done_cyc = cyc + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Launches a campaign and returns the cycle in which done was seen (0 = none)
  task automatic run(input string nm, input int abort_at, input int start_at, output int got);
    launch();
    got = 0;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      start = (c == start_at);
      if (c == 1) chk({nm, "_cleared"}, 32'(detected), 32'h0);
      if (c == abort_at) abort = 1'b1;
      if (done) begin
        got = c;
        break;
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        abort = 1'b0;
        chk({nm, "_abort_busy"}, 32'(busy), 32'h0);
        chk({nm, "_abort_site_out"}, 32'(site_out), 32'(site_in));
        chk({nm, "_abort_tv"}, 32'(tv), 32'h0);
      end
      if (abort_at > 0 && c > abort_at + 20) break;
    end
    start = 1'b0;
    if (got > 0) begin
      chk({nm, "_busy_at_done"}, 32'(busy), 32'h1);
      @(negedge clk);
      chk({nm, "_busy_after"}, 32'(busy), 32'h0);
      chk({nm, "_done_pulse"}, 32'(done), 32'h0);
    end
  endtask

  initial begin
    logic [2*N-1:0] e_det;
    int e_cyc, got;

    tbl[0] = '{0, 10'h3A5, 20'h00000, 661};
    tbl[1] = '{1, 10'h001, 20'h00020, 631};
    tbl[2] = '{2, 10'h001, 20'h00001, 661};

    site_in_r = N'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_site_out", 32'(site_out), 32'(site_in));
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_detected", 32'(detected), 32'h0);
    chk("rst_det_count", 32'(det_count), 32'h0);
    chk("rst_tv", 32'(tv), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].md;
      site_in_r = tbl[i].sin;
      run($sformatf("tbl%0d", i), 0, 0, got);
      chk($sformatf("tbl%0d_done_cycle", i), 32'(got), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_detected", i), 32'(detected), 32'(tbl[i].det));
      chk($sformatf("tbl%0d_det_count", i), 32'(det_count), 32'($countones(tbl[i].det)));
    end

    for (int r = 0; r < 4; r++) begin
      mode = 4;
      for (int v = 0; v < NV; v++) nets_flat[v*N +: N] = N'($urandom);
      m0 = N'($urandom);
      m1 = N'($urandom & $urandom);
      predict(4, 0, e_det, e_cyc);
      run($sformatf("rnd%0d", r), 0, 0, got);
      chk($sformatf("rnd%0d_done_cycle", r), 32'(got), 32'(e_cyc));
      chk($sformatf("rnd%0d_detected", r), 32'(detected), 32'(e_det));
      chk($sformatf("rnd%0d_det_count", r), 32'(det_count), 32'($countones(e_det)));
    end

    mode = 3;
    site_in_r = 10'h003;
    predict(3, 100, e_det, e_cyc);
    run("abort", 100, 0, got);
    chk("abort_no_done", 32'(got), 32'h0);
    chk("abort_detected", 32'(detected), 32'(e_det));
    chk("abort_det_count", 32'(det_count), 32'($countones(e_det)));
    predict(3, 0, e_det, e_cyc);
    run("rerun", 0, 0, got);
    chk("rerun_done_cycle", 32'(got), 32'(e_cyc));
    chk("rerun_detected", 32'(detected), 32'(e_det));

    mode = 0;
    site_in_r = N'($urandom);
    run("busy_start", 0, 50, got);
    chk("busy_start_done_cycle", 32'(got), 32'd661);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("start_abort_busy2", 32'(busy), 32'h0);

    mode = 3;
    site_in_r = 10'h003;
    launch();
    repeat (200) @(negedge clk);
    chk("mid_pre_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_detected", 32'(detected), 32'h0);
    chk("mid_rst_det_count", 32'(det_count), 32'h0);
    chk("mid_rst_tv", 32'(tv), 32'h0);
    chk("mid_rst_site_out", 32'(site_out), 32'(site_in));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
